// File: rtl/scan_chain_ctrl_pkg.sv
// scan_chain_ctrl_pkg: shared state encoding and MISR constants for scan_chain_ctrl.
package scan_chain_ctrl_pkg;
   typedef enum logic [2:0] {IDLE, SHIFT, CAPTURE, UNLOAD, RESP} state_e;
   localparam int MISR_W = 16;
   localparam logic [MISR_W-1:0] MISR_POLY = 16'h1021;
endpackage

// File: rtl/scan_chain_ctrl_misr.sv
// scan_chain_ctrl_misr: 16-bit serial-input signature register compacting the unloaded scan stream.
module scan_chain_ctrl_misr
   import scan_chain_ctrl_pkg::*;
(
   input  logic              CLK,
   input  logic              RESET,
   input  logic              CLR,
   input  logic              EN,
   input  logic              SI,
   output logic [MISR_W-1:0] SIG
);
   logic [MISR_W-1:0] sig_q, sig_d;
   always_comb begin
      sig_d = CLR ? '0
            : EN  ? ({sig_q[MISR_W-2:0], 1'b0} ^ (sig_q[MISR_W-1] ? MISR_POLY : '0) ^ {{(MISR_W-1){1'b0}}, SI})
            : sig_q;
   end
   always_ff @(posedge CLK) begin
      if (RESET) sig_q <= '0;
      else       sig_q <= sig_d;
   end
   assign SIG = sig_q;
endmodule

// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: loads a pattern into one scan chain, pulses capture, unloads the response.
// Optional MISR signature over the unloaded stream when SCAN_CHAIN_CTRL_MISR_EN is defined.
module scan_chain_ctrl
   import scan_chain_ctrl_pkg::*;
#(
   parameter int CHAIN_LEN      = 8,
   parameter int CAPTURE_CYCLES = 1
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 PAT_VALID,
   output logic                 PAT_READY,
   input  logic [CHAIN_LEN-1:0] PAT_DATA,
   output logic                 SCE,
   output logic                 SCD,
   input  logic                 SO,
   output logic                 RESP_VALID,
   input  logic                 RESP_READY,
   output logic [CHAIN_LEN-1:0] RESP_DATA,
   output logic                 BUSY,
   input  logic                 SIG_CLR,
   output logic [MISR_W-1:0]    SIGNATURE
);
   localparam int CNT_W = $clog2(CHAIN_LEN + CAPTURE_CYCLES) + 1;
   localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CHAIN_LEN - 1);
   localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(CAPTURE_CYCLES - 1);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [CHAIN_LEN-1:0] load_q, load_d;
   logic [CHAIN_LEN-1:0] resp_q, resp_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load_d  = load_q;
      resp_d  = resp_q;
      case (state_q)
         IDLE: begin
            if (PAT_VALID) begin
               state_d = SHIFT;
               cnt_d   = '0;
               load_d  = PAT_DATA;
            end
         end
         SHIFT: begin
            load_d  = load_q >> 1;
            state_d = (cnt_q == SHIFT_LAST) ? CAPTURE : SHIFT;
            cnt_d   = (cnt_q == SHIFT_LAST) ? '0 : cnt_q + 1'b1;
         end
         CAPTURE: begin
            state_d = (cnt_q == CAP_LAST) ? UNLOAD : CAPTURE;
            cnt_d   = (cnt_q == CAP_LAST) ? '0 : cnt_q + 1'b1;
         end
         UNLOAD: begin
            // flop 0 leaves first, so after CHAIN_LEN shifts it sits at bit 0
            resp_d  = {SO, resp_q[CHAIN_LEN-1:1]};
            state_d = (cnt_q == SHIFT_LAST) ? RESP : UNLOAD;
            cnt_d   = (cnt_q == SHIFT_LAST) ? '0 : cnt_q + 1'b1;
         end
         RESP:    state_d = RESP_READY ? IDLE : RESP;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         load_q  <= '0;
         resp_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         load_q  <= load_d;
         resp_q  <= resp_d;
      end
   end

   assign PAT_READY  = (state_q == IDLE) && !RESET;
   assign SCE        = (state_q == SHIFT) || (state_q == UNLOAD);
   assign SCD        = (state_q == SHIFT) && load_q[0];
   assign RESP_VALID = (state_q == RESP);
   assign RESP_DATA  = resp_q;
   assign BUSY       = (state_q == SHIFT) || (state_q == CAPTURE) || (state_q == UNLOAD);

`ifdef SCAN_CHAIN_CTRL_MISR_EN
   scan_chain_ctrl_misr u_misr (
      .CLK   (CLK),
      .RESET (RESET),
      .CLR   (SIG_CLR),
      .EN    (state_q == UNLOAD),
      .SI    (SO),
      .SIG   (SIGNATURE)
   );
`else
   logic sig_clr_unused;
   assign sig_clr_unused = SIG_CLR;
   assign SIGNATURE      = '0;
`endif
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb_scan_chain_ctrl: random and directed transactions against a model chain whose flops capture ~Q.
module tb_scan_chain_ctrl;
   localparam int L   = 8;
   localparam int CAP = 1;
`ifdef SCAN_CHAIN_CTRL_MISR_EN
   localparam bit MISR_ON = 1'b1;
`else
   localparam bit MISR_ON = 1'b0;
`endif

   logic         CLK = 1'b0;
   logic         RESET, PAT_VALID, PAT_READY, SCE, SCD, SO;
   logic         RESP_VALID, RESP_READY, BUSY, SIG_CLR;
   logic [L-1:0] PAT_DATA, RESP_DATA, chain;
   logic [15:0]  SIGNATURE, sig_m;
   int           n_chk = 0, n_fail = 0;

   scan_chain_ctrl #(.CHAIN_LEN(L), .CAPTURE_CYCLES(CAP)) dut (
      .CLK(CLK), .RESET(RESET), .PAT_VALID(PAT_VALID), .PAT_READY(PAT_READY),
      .PAT_DATA(PAT_DATA), .SCE(SCE), .SCD(SCD), .SO(SO), .RESP_VALID(RESP_VALID),
      .RESP_READY(RESP_READY), .RESP_DATA(RESP_DATA), .BUSY(BUSY),
      .SIG_CLR(SIG_CLR), .SIGNATURE(SIGNATURE)
   );

   always #5 CLK = ~CLK;

   // scan flops: shift on SCE, otherwise functional D = ~Q
   always @(posedge CLK) chain <= SCE ? {SCD, chain[L-1:1]} : ~chain;
   assign SO = chain[0];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] misr_step(input logic [15:0] s, input logic b);
      return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0) ^ {15'b0, b};
   endfunction

   task automatic run_txn(input logic [L-1:0] pat, input int hold);
      int cyc, lowc, guard;
      logic [L-1:0] scd_seq, exp_resp;
      logic ready_seen, busy_bad, scd_bad;
      guard = 0;
      while (!PAT_READY && guard < 50) begin
         @(negedge CLK);
         guard++;
      end
      check("pat_ready_wait", PAT_READY, 1);
      PAT_VALID  = 1'b1;
      PAT_DATA   = pat;
      RESP_READY = (hold == 0);
      @(negedge CLK);
      PAT_VALID = 1'b0;
      PAT_DATA  = L'($urandom);
      cyc = 1; lowc = 0; scd_seq = '0;
      ready_seen = 1'b0; busy_bad = 1'b0; scd_bad = 1'b0;
      while (!RESP_VALID && cyc < 100) begin
         if (cyc <= L && SCE) scd_seq[cyc-1] = SCD;
         if (cyc > L && SCD) scd_bad = 1'b1;
         if (!SCE) lowc++;
         if (PAT_READY) ready_seen = 1'b1;
         if (!BUSY) busy_bad = 1'b1;
         PAT_VALID = 1'($urandom_range(0, 1));
         @(negedge CLK);
         cyc++;
      end
      exp_resp = ~pat;
      for (int k = 0; k < L; k++) sig_m = misr_step(sig_m, exp_resp[k]);
      check("latency", cyc, 2 * L + CAP + 1);
      check("scd_seq", scd_seq, pat);
      check("scd_unload_low", scd_bad, 0);
      check("sce_low_cycles", lowc, CAP);
      check("pat_ready_busy", ready_seen, 0);
      check("busy_high", busy_bad, 0);
      check("resp_data", RESP_DATA, exp_resp);
      check("signature", SIGNATURE, MISR_ON ? sig_m : 16'h0);
      PAT_VALID = (hold > 0);
      for (int i = 0; i < hold; i++) begin
         @(negedge CLK);
         check("hold_valid", RESP_VALID, 1);
         check("hold_data", RESP_DATA, exp_resp);
         check("hold_pat_ready", PAT_READY, 0);
      end
      PAT_VALID  = 1'b0;
      RESP_READY = 1'b1;
      @(negedge CLK);
      check("idle_valid", RESP_VALID, 0);
      check("idle_pat_ready", PAT_READY, 1);
      RESP_READY = 1'b0;
   endtask

   initial begin
      RESET = 1'b1; PAT_VALID = 1'b0; PAT_DATA = '0; RESP_READY = 1'b0; SIG_CLR = 1'b0;
      sig_m = '0;
      repeat (2) @(negedge CLK);
      check("rst_pat_ready", PAT_READY, 0);
      check("rst_sce", SCE, 0);
      check("rst_scd", SCD, 0);
      check("rst_resp_valid", RESP_VALID, 0);
      check("rst_resp_data", RESP_DATA, 0);
      check("rst_busy", BUSY, 0);
      check("rst_signature", SIGNATURE, 0);
      RESET = 1'b0;
      @(negedge CLK);
      check("post_rst_ready", PAT_READY, 1);

      SIG_CLR = 1'b1;
      @(negedge CLK);
      SIG_CLR = 1'b0;
      sig_m = '0;
      run_txn(8'hA5, 0);
      run_txn(8'h00, 0);
      run_txn(8'hFF, 0);
      run_txn(8'h5A, 10);

      SIG_CLR = 1'b1;
      @(negedge CLK);
      SIG_CLR = 1'b0;
      sig_m = '0;
      check("sig_clr", SIGNATURE, 0);

      PAT_VALID = 1'b1;
      PAT_DATA  = 8'h96;
      @(negedge CLK);
      PAT_VALID = 1'b0;
      repeat (L + CAP + 2) @(negedge CLK);
      check("abort_in_unload", SCE, 1);
      RESET = 1'b1;
      @(negedge CLK);
      sig_m = '0;
      check("abort_sce", SCE, 0);
      check("abort_scd", SCD, 0);
      check("abort_valid", RESP_VALID, 0);
      check("abort_busy", BUSY, 0);
      check("abort_data", RESP_DATA, 0);
      check("abort_sig", SIGNATURE, 0);
      RESET = 1'b0;
      @(negedge CLK);
      check("abort_ready", PAT_READY, 1);
      run_txn(8'h3C, 0);

      for (int n = 0; n < 20; n++) run_txn(L'($urandom), $urandom_range(0, 3));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
